rem_q_divider_core: RTL and testbench

Parametrised iterative restoring divider built around a combined remainder/quotient shift register, with its own control FSM and start/done handshake. It generalises the fixed 64-bit remainder/quotient register: configurable width, optional signed mode, divide-by-zero handling, and a one-iteration-per-cycle shift-and-subtract step instead of separate shift and write cycles. It sits in the execution datapath as a self-contained multi-cycle divide unit.

---
 rtl/rem_q_divider_core.sv | 113 +++++++++++
 tb/tb_rem_q_divider_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rem_q_divider_core.sv
// rtl/rem_q_divider_core.sv - iterative restoring divider on a combined remainder/quotient register
// One shift-and-subtract step per cycle, followed by a sign/divide-by-zero fix-up cycle.
module rem_q_divider_core #(
  parameter int WIDTH     = 64,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem_reg, q_reg, dvsr_reg;
  logic [CW-1:0]    count;
  logic             neg_q, neg_r, dbz_flag;

  logic             eff_signed, dvd_neg, dvs_neg, dvs_zero, trial_ok;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    eff_signed = signed_mode & SIGNED_EN;
    dvd_neg    = eff_signed & dividend[WIDTH-1];
    dvs_neg    = eff_signed & divisor[WIDTH-1];
    dvd_abs    = dvd_neg ? -dividend : dividend;
    dvs_abs    = dvs_neg ? -divisor : divisor;
    dvs_zero   = (divisor == '0);
    // Full remainder plus the incoming quotient bit needs WIDTH+1 bits.
    shifted    = {rem_reg, q_reg[WIDTH-1]};
    trial      = shifted - {1'b0, dvsr_reg};
    trial_ok   = (shifted >= {1'b0, dvsr_reg});
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = dvs_zero ? FIX : CALC;
      CALC:    if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_reg     <= '0;
      q_reg       <= '0;
      dvsr_reg    <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_flag    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            rem_reg  <= '0;
            dvsr_reg <= dvs_abs;
            count    <= CW'(WIDTH);
            busy     <= 1'b1;
            dbz_flag <= dvs_zero;
            // A zero divisor skips CALC, so keep the raw dividend for the remainder.
            q_reg    <= dvs_zero ? dividend : dvd_abs;
          end
        end
        CALC: begin
          rem_reg <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          q_reg   <= {q_reg[WIDTH-2:0], trial_ok};
          count   <= count - 1'b1;
        end
        FIX: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= dbz_flag;
          if (dbz_flag) begin
            quotient  <= '1;
            remainder <= q_reg;
          end else begin
            quotient  <= neg_q ? -q_reg : q_reg;
            remainder <= neg_r ? -rem_reg : rem_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rem_q_divider_core.sv
// tb/tb_rem_q_divider_core.sv - self-checking bench for rem_q_divider_core
// 8-bit signed/unsigned instances for directed cases, 64-bit instance for random operands.
module tb_rem_q_divider_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start8, sm8;
  logic [7:0] a8, b8;
  logic       busy8, done8, dz8, busy8u, done8u, dz8u;
  logic [7:0] q8, r8, q8u, r8u;

  logic        start64, sm64;
  logic [63:0] a64, b64, q64, r64;
  logic        busy64, done64, dz64;

  int vec = 0;
  int err = 0;

  rem_q_divider_core #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8));

  rem_q_divider_core #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8u (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8u), .done(done8u),
    .quotient(q8u), .remainder(r8u), .div_by_zero(dz8u));

  rem_q_divider_core #(.WIDTH(64), .SIGNED_EN(1'b1)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .signed_mode(sm64),
    .dividend(a64), .divisor(b64), .busy(busy64), .done(done64),
    .quotient(q64), .remainder(r64), .div_by_zero(dz64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec++;
    assert (obs === expv) else begin
      err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Truncating division on 64-bit operands; narrower widths pass extended operands.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                output logic [63:0] q, output logic [63:0] r);
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (sgn && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = -a;
      r = '0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] x, input logic sgn);
    return (sgn && x[63]) ? -x : x;
  endfunction

  task automatic op8(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b);
    logic [63:0] ea, eb, eq, er, uq, ur;
    int lat;
    ea = sm ? {{56{a[7]}}, a} : {56'd0, a};
    eb = sm ? {{56{b[7]}}, b} : {56'd0, b};
    model(ea, eb, sm, eq, er);
    model({56'd0, a}, {56'd0, b}, 1'b0, uq, ur);
    @(negedge clk);
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; sm8 = ~sm; a8 = 8'($urandom); b8 = 8'($urandom);
    chk({tag, "_busy"}, 64'(busy8), 64'd1);
    lat = 0;
    while (done8 !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), (b == 8'd0) ? 64'd1 : 64'd9);
    chk({tag, "_q"}, 64'(q8), 64'(eq[7:0]));
    chk({tag, "_r"}, 64'(r8), 64'(er[7:0]));
    chk({tag, "_dz"}, 64'(dz8), 64'(b == 8'd0));
    chk({tag, "_busy_end"}, 64'(busy8), 64'd0);
    chk({tag, "_u_done"}, 64'(done8u), 64'd1);
    chk({tag, "_u_q"}, 64'(q8u), 64'(uq[7:0]));
    chk({tag, "_u_r"}, 64'(r8u), 64'(ur[7:0]));
  endtask

  task automatic op64(input logic b2b, input logic sm, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] eq, er;
    int lat;
    model(a, b, sm, eq, er);
    if (!b2b) @(negedge clk);
    start64 = 1'b1; sm64 = sm; a64 = a; b64 = b;
    @(posedge clk);
    @(negedge clk);
    start64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    lat = 0;
    while (done64 !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("w64_lat", 64'(lat), (b == 64'd0) ? 64'd1 : 64'd65);
    chk("w64_q", q64, eq);
    chk("w64_r", r64, er);
    chk("w64_dz", 64'(dz64), 64'(b == 64'd0));
    if (b != 64'd0) begin
      chk("w64_inv_eq", q64 * b + r64, a);
      chk("w64_inv_mag", 64'(mag(r64, sm) < mag(b, sm)), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        seen;
    int          sel;

    reset = 1'b1; start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start64 = 1'b0; sm64 = 1'b0; a64 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_q", 64'(q8), 64'd0);
    chk("rst_r", 64'(r8), 64'd0);
    chk("rst_dz", 64'(dz8), 64'd0);
    chk("rst_q64", q64, 64'd0);
    reset = 1'b0;

    op8("u200_7", 1'b0, 8'd200, 8'd7);
    chk("u200_7_const_q", 64'(q8), 64'h1C);
    chk("u200_7_const_r", 64'(r8), 64'h04);
    op8("s_m100_7", 1'b1, 8'h9C, 8'h07);
    chk("s_m100_7_const_q", 64'(q8), 64'hF2);
    chk("s_m100_7_const_r", 64'(r8), 64'hFE);
    op8("s_100_m7", 1'b1, 8'd100, 8'hF9);
    op8("dbz_u", 1'b0, 8'h5A, 8'h00);
    op8("dbz_s", 1'b1, 8'h5A, 8'h00);
    chk("dbz_s_const_q", 64'(q8), 64'hFF);
    op8("after_dbz", 1'b0, 8'd9, 8'd3);
    op8("s_ovf", 1'b1, 8'h80, 8'hFF);
    chk("s_ovf_const_q", 64'(q8), 64'h80);
    for (int i = 0; i < 20; i++)
      op8("rnd8", 1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));

    // Start pulse during CALC must be ignored.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 100 && done8 !== 1'b1; i++) @(negedge clk);
    chk("midcalc_done", 64'(done8), 64'd1);
    chk("midcalc_q", 64'(q8), 64'h1C);
    chk("midcalc_r", 64'(r8), 64'h04);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) seen = 1'b1;
    end
    chk("midcalc_no_second", 64'(seen), 64'd0);

    // Reset at edge N+4 aborts the operation.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd201; b8 = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_q", 64'(q8), 64'd0);
    chk("abort_r", 64'(r8), 64'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done8 === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    op8("post_reset", 1'b0, 8'd200, 8'd7);

    for (int i = 0; i < 1000; i++) begin
      ra  = {$urandom, $urandom};
      sel = $urandom_range(0, 15);
      case (sel)
        0:       rb = 64'd0;
        1:       rb = '1;
        2:       begin ra = 64'h8000_0000_0000_0000; rb = '1; end
        3, 4:    rb = 64'($urandom_range(1, 255));
        5, 6, 7: rb = {32'd0, $urandom};
        8:       begin ra = ra >> $urandom_range(0, 63); rb = {$urandom, $urandom}; end
        default: rb = {$urandom, $urandom};
      endcase
      op64((i > 0) && ($urandom_range(0, 1) == 1), 1'($urandom), ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
